// File: rtl/rgbw_frame_scheduler.sv
// Shadow-buffered RGBW frame scheduler: commits received frames only at PWM period boundaries
// and fades intensity to zero when the SPI host stops sending frames.
module rgbw_frame_scheduler #(
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned FADE_STEP     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [7:0]  lint_in,
  input  logic [7:0]  color_idx_in,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic [7:0]  white_in,
  input  logic [7:0]  mode_in,
  input  logic        pwm_sof,
  input  logic        tick,
  input  logic        ovr_clr,
  output logic [7:0]  lint_out,
  output logic [7:0]  color_idx_out,
  output logic [15:0] red_out,
  output logic [15:0] green_out,
  output logic [15:0] blue_out,
  output logic [15:0] white_out,
  output logic [7:0]  mode_out,
  output logic        applied,
  output logic        pending,
  output logic        overrun,
  output logic        timeout
);

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_TICKS);
  localparam logic [7:0]  STEP   = 8'(FADE_STEP);

  typedef enum logic [1:0] {RUN, FADE, DARK} state_t;

  state_t      state;
  logic [7:0]  lint_sh, idx_sh, red_sh, green_sh, blue_sh, white_sh, mode_sh;
  logic [15:0] wd_cnt;
  logic        fade_due;

  logic        commit;
  logic        fade_commit;
  logic        ovr_event;
  logic [8:0]  lint_diff;
  logic [7:0]  lint_dec;
  logic [15:0] wd_inc;

  // A pending commit always beats a fade step; a new frame cancels the fade outright.
  assign commit      = pwm_sof & pending;
  assign fade_commit = (state == FADE) & pwm_sof & fade_due & ~frame_valid & ~commit;
  assign ovr_event   = frame_valid & pending & ~commit;
  assign lint_diff   = {1'b0, lint_out} - {1'b0, STEP};
  assign lint_dec    = lint_diff[8] ? 8'h00 : lint_diff[7:0];
  assign wd_inc      = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      lint_sh       <= '0;
      idx_sh        <= '0;
      red_sh        <= '0;
      green_sh      <= '0;
      blue_sh       <= '0;
      white_sh      <= '0;
      mode_sh       <= '0;
      wd_cnt        <= '0;
      fade_due      <= 1'b0;
      lint_out      <= '0;
      color_idx_out <= '0;
      red_out       <= '0;
      green_out     <= '0;
      blue_out      <= '0;
      white_out     <= '0;
      mode_out      <= '0;
      applied       <= 1'b0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      applied <= commit | fade_commit;

      if (frame_valid) begin
        lint_sh  <= lint_in;
        idx_sh   <= color_idx_in;
        red_sh   <= red_in;
        green_sh <= green_in;
        blue_sh  <= blue_in;
        white_sh <= white_in;
        mode_sh  <= mode_in;
      end

      if (frame_valid)  pending <= 1'b1;
      else if (commit)  pending <= 1'b0;

      if (ovr_event)    overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;

      if (commit) begin
        lint_out      <= lint_sh;
        color_idx_out <= idx_sh;
        red_out       <= {red_sh, 8'h00};
        green_out     <= {green_sh, 8'h00};
        blue_out      <= {blue_sh, 8'h00};
        white_out     <= {white_sh, 8'h00};
        mode_out      <= mode_sh;
      end else if (fade_commit) begin
        lint_out <= lint_dec;
      end

      case (state)
        RUN: begin
          if (frame_valid) begin
            wd_cnt <= '0;
          end else if (tick) begin
            wd_cnt <= wd_inc;
            if ((TO_CNT != 16'd0) && (wd_inc >= TO_CNT)) begin
              state   <= FADE;
              timeout <= 1'b1;
            end
          end
        end
        default: begin
          if (frame_valid || commit) begin
            state    <= RUN;
            timeout  <= 1'b0;
            wd_cnt   <= '0;
            fade_due <= 1'b0;
          end else if (state == FADE) begin
            if (fade_commit) fade_due <= 1'b0;
            if (tick)        fade_due <= 1'b1;
            if ((fade_commit ? lint_dec : lint_out) == 8'h00) state <= DARK;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_frame_scheduler.sv
// Scoreboard bench for rgbw_frame_scheduler: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the commit/fade rules.
module tb_rgbw_frame_scheduler;

  localparam int TO = 4;
  localparam int FS = 'h30;

  typedef struct packed {
    logic [7:0] lint;
    logic [7:0] idx;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] w;
    logic [7:0] mode;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_valid = 1'b0;
  logic [7:0]  lint_in = '0, color_idx_in = '0, red_in = '0, green_in = '0;
  logic [7:0]  blue_in = '0, white_in = '0, mode_in = '0;
  logic        pwm_sof = 1'b0, tick = 1'b0, ovr_clr = 1'b0;
  logic [7:0]  lint_out, color_idx_out, mode_out;
  logic [15:0] red_out, green_out, blue_out, white_out;
  logic        applied, pending, overrun, timeout;

  rgbw_frame_scheduler #(.TIMEOUT_TICKS(TO), .FADE_STEP(FS)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid),
    .lint_in(lint_in), .color_idx_in(color_idx_in), .red_in(red_in),
    .green_in(green_in), .blue_in(blue_in), .white_in(white_in), .mode_in(mode_in),
    .pwm_sof(pwm_sof), .tick(tick), .ovr_clr(ovr_clr),
    .lint_out(lint_out), .color_idx_out(color_idx_out), .red_out(red_out),
    .green_out(green_out), .blue_out(blue_out), .white_out(white_out), .mode_out(mode_out),
    .applied(applied), .pending(pending), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  out_t     exp_q[$];
  bit [3:0] flag_q[$];

  // Model state: shadow, committed outputs, flags, watchdog mode (0 run, 1 fade, 2 dark)
  out_t m_sh, m_out;
  bit   m_pend, m_ovr, m_due;
  int   m_state, m_wd;

  function automatic out_t mk(input logic [7:0] l, i, r, g, b, w, m);
    out_t f;
    f = '{lint: l, idx: i, r: r, g: g, b: b, w: w, mode: m};
    return f;
  endfunction

  function automatic out_t dut_out();
    return mk(lint_out, color_idx_out, red_out[15:8], green_out[15:8],
              blue_out[15:8], white_out[15:8], mode_out);
  endfunction

  task automatic model_reset();
    m_sh = '0; m_out = '0; m_pend = 0; m_ovr = 0; m_due = 0; m_state = 0; m_wd = 0;
  endtask

  // Effect of the upcoming clock edge given the inputs currently driven.
  task automatic model_step();
    bit   commit, fade;
    int   nl;
    commit = pwm_sof && m_pend;
    fade   = (m_state == 1) && pwm_sof && m_due && !frame_valid && !commit;
    if (commit) begin
      m_out = m_sh;
      exp_q.push_back(m_out);
    end else if (fade) begin
      nl = int'(m_out.lint) - FS;
      if (nl < 0) nl = 0;
      m_out.lint = 8'(nl);
      exp_q.push_back(m_out);
    end
    if (frame_valid && m_pend && !commit) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    if (frame_valid) begin
      m_sh = mk(lint_in, color_idx_in, red_in, green_in, blue_in, white_in, mode_in);
      m_pend = 1;
    end else if (commit) m_pend = 0;
    if (m_state == 0) begin
      if (frame_valid) m_wd = 0;
      else if (tick) begin
        if (m_wd < 65535) m_wd++;
        if (m_wd >= TO) m_state = 1;
      end
    end else if (frame_valid || commit) begin
      m_state = 0; m_wd = 0; m_due = 0;
    end else if (m_state == 1) begin
      if (fade) m_due = 0;
      if (tick) m_due = 1;
      if (m_out.lint == 8'h00) m_state = 2;
    end
    flag_q.push_back({m_pend, m_ovr, m_state != 0, commit || fade});
  endtask

  task automatic drive(input bit fv, input out_t f, input bit sof, input bit tk, input bit clr);
    @(negedge clk);
    reset = 1'b1;
    frame_valid = fv; lint_in = f.lint; color_idx_in = f.idx; red_in = f.r;
    green_in = f.g; blue_in = f.b; white_in = f.w; mode_in = f.mode;
    pwm_sof = sof; tick = tk; ovr_clr = clr;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    frame_valid = 0; pwm_sof = 0; tick = 0; ovr_clr = 0;
    model_reset();
    #1;
    checks++;
    if ({dut_out(), red_out[7:0], applied, pending, overrun, timeout} != '0) begin
      errors++;
      $display("FAIL reset_async got outs=%h flags=%b exp all zero", dut_out(),
               {applied, pending, overrun, timeout});
    end
    flag_q.push_back(4'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flag_q.push_back(4'b0);
    end
  endtask

  // Monitor: per-cycle flag check, output check on every applied pulse.
  out_t mon_last;
  initial begin
    out_t     e;
    bit [3:0] fe, fg;
    mon_last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (flag_q.size() == 0) continue;
      fe = flag_q.pop_front();
      fg = {pending, overrun, timeout, applied};
      if (!reset) mon_last = '0;
      checks++;
      if (fg != fe) begin
        errors++;
        $display("FAIL flags(pend,ovr,tmo,appl) t=%0t got=%b exp=%b", $time, fg, fe);
      end
      if (applied) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL applied_unexpected t=%0t got=1 exp=no commit", $time);
        end else begin
          e = exp_q.pop_front();
          mon_last = e;
          if (dut_out() != e) begin
            errors++;
            $display("FAIL commit_outputs t=%0t got=%h exp=%h", $time, dut_out(), e);
          end
        end
      end
      checks++;
      if (dut_out() != mon_last || {red_out[7:0], green_out[7:0], blue_out[7:0], white_out[7:0]} != '0) begin
        errors++;
        $display("FAIL held_outputs t=%0t got=%h lo=%h exp=%h lo=0", $time, dut_out(),
                 {red_out[7:0], green_out[7:0], blue_out[7:0], white_out[7:0]}, mon_last);
      end
    end
  end

  initial begin
    out_t f;
    do_reset();
    // First frame, then commit on a period boundary
    drive(1, mk(8'h80, 8'd3, 8'h12, 8'h34, 8'h56, 8'h78, 8'd1), 0, 0, 0);
    idle(3);
    drive(0, '0, 1, 0, 0);
    idle(2);
    // Overrun, then clear
    drive(1, mk(8'h80, 8'd1, 8'h11, 8'h01, 8'h02, 8'h03, 8'd0), 0, 0, 0);
    idle(1);
    drive(1, mk(8'h80, 8'd2, 8'h22, 8'h04, 8'h05, 8'h06, 8'd0), 0, 0, 0);
    idle(1);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 0, 0, 1);
    idle(1);
    // Frame coinciding with a commit
    drive(1, mk(8'h80, 8'd2, 8'h22, 8'h07, 8'h08, 8'h09, 8'd2), 0, 0, 0);
    idle(1);
    drive(1, mk(8'h80, 8'd4, 8'h33, 8'h0a, 8'h0b, 8'h0c, 8'd3), 1, 0, 0);
    idle(1);
    drive(0, '0, 1, 0, 0);
    idle(1);
    // Watchdog fade to dark, one tick per period
    for (int p = 0; p < 12; p++) begin
      drive(0, '0, 0, 1, 0);
      idle(1);
      drive(0, '0, 1, 0, 0);
      idle(2);
    end
    // Wake from dark
    drive(1, mk(8'h40, 8'd5, 8'h44, 8'h55, 8'h66, 8'h77, 8'd4), 0, 0, 0);
    idle(1);
    drive(0, '0, 1, 0, 0);
    idle(1);
    // Pending frame while the watchdog fades, then reset mid-fade
    drive(1, mk(8'h90, 8'd6, 8'h99, 8'h88, 8'h77, 8'h66, 8'd5), 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(0, '0, 0, 1, 0);
      idle(1);
    end
    do_reset();
    drive(0, '0, 1, 0, 0);
    idle(2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      f = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom));
      drive($urandom_range(0, 9) == 0, f, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL commits_missing got=%0d leftover exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgbw_frame_scheduler.md
# rgbw_frame_scheduler

Sits between the SPI frame decoder and the colour generator, and controls when a received frame actually reaches the LEDs. Each complete frame is captured into a shadow buffer, and the buffer is committed to the colour generator only at a PWM period boundary, so duty cycles never change mid-period. A watchdog counts external ticks. If the SPI host falls silent, the block fades the light intensity (lint) down to zero, again committing only at period boundaries.

## Interface
Parameters:
- TIMEOUT_TICKS, 1000: ticks without a frame before fade starts; 0 disables the watchdog; max 65535.
- FADE_STEP, 1: lint decrement per fade commit; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle pulse; frame fields below are valid in that cycle.
- lint_in  in  8  light intensity of frame.
- color_idx_in  in  8  colour index of frame.
- red_in, green_in, blue_in, white_in  in  8 each  channel bytes of frame.
- mode_in  in  8  mode byte of frame.
- pwm_sof  in  1  one-cycle pulse at start of each PWM period.
- tick  in  1  one-cycle timebase pulse for the watchdog (nominally 1 ms).
- ovr_clr  in  1  clears the overrun flag.
- lint_out  out  8  committed intensity.
- color_idx_out  out  8  committed colour index.
- red_out, green_out, blue_out, white_out  out  16 each  committed channel, formatted as {byte, 8'h00}.
- mode_out  out  8  committed mode.
- applied  out  1  one-cycle pulse in the cycle after any commit.
- pending  out  1  shadow holds an uncommitted frame.
- overrun  out  1  sticky flag: a frame was overwritten before it was committed.
- timeout  out  1  high while in FADE or DARK.

## Operation
Shadow capture:
- On frame_valid, all seven fields load into the shadow registers and pending is set.
- If pending is already set and no commit happens in the same cycle, overrun is set. overrun clears only via ovr_clr or reset.
- If ovr_clr and a new overrun event occur in the same cycle, overrun stays set.

Commit:
- A commit happens on the edge where pwm_sof=1 and pending=1. The shadow is copied to the outputs and pending is cleared.
- If frame_valid coincides with a commit, the old shadow is committed and the new frame is captured. pending stays 1 and overrun is not set.
- If frame_valid arrives with pending=0 in the same cycle as pwm_sof, the frame is captured only. It commits at the next pwm_sof; there is no same-cycle bypass.

State machine (reset to RUN):
- RUN: wd_cnt (16 bit) increments on tick and clears to 0 on frame_valid.
  - If frame_valid and tick occur in the same cycle, wd_cnt goes to 0.
  - When wd_cnt reaches TIMEOUT_TICKS (and TIMEOUT_TICKS≠0), go to FADE; wd_cnt holds.
- FADE: each tick sets fade_due.
  - On pwm_sof with fade_due=1: lint_out ← max(lint_out − FADE_STEP, 0), fade_due is cleared, and applied pulses.
  - Colour, mode and index outputs are not touched by the fade.
  - When lint_out reaches 0, go to DARK.
- DARK: outputs hold.
- Exit from FADE or DARK: frame_valid returns the block to RUN and clears wd_cnt and fade_due; the frame then follows normal capture and commit.
- Fade/commit priority: if a pending commit and fade_due coincide on the same pwm_sof, the commit wins, fade_due is cleared, and the state returns to RUN.

Arithmetic:
- The lint subtraction is 9-bit with saturation at 0.
- wd_cnt saturates and never wraps.

Reset:
- Every output and internal register goes to 0, including all committed outputs, shadow, wd_cnt and fade_due.
- Flags go to 0: pending, overrun, timeout, applied.
- State goes to RUN.
- Asserting reset mid-frame or mid-fade discards the shadow with no commit.

## Timing
- Capture latency: pending reads 1 in the cycle after frame_valid.
- Commit latency: outputs and applied change on the first pwm_sof edge where pending=1. applied is high for exactly the following cycle.
- Minimum frame-to-output delay: 2 cycles, when pwm_sof arrives the cycle after frame_valid.
- timeout rises in the cycle after the tick that makes wd_cnt equal TIMEOUT_TICKS, and falls in the cycle after frame_valid.
- All inputs are synchronous to clk. pwm_sof and tick are assumed to be single-cycle pulses; no edge detection is done here.

## Test plan
- Reset, then send a frame {lint 0x80, idx 3, R 0x12, G 0x34, B 0x56, W 0x78, mode 1} with no pwm_sof.
  - Outputs stay 0 and pending=1.
  - On pwm_sof: red_out=0x1200, white_out=0x7800, lint_out=0x80, one applied pulse, pending=0.
- Send two frames (red 0x11, then 0x22) before a pwm_sof → overrun=1 and red_out becomes 0x2200. Pulse ovr_clr → overrun=0.
- Drive frame_valid (red 0x33) in the same cycle as pwm_sof with a pending red 0x22.
  - red_out becomes 0x2200, pending stays 1, overrun stays 0.
  - At the next pwm_sof, red_out becomes 0x3300.
- TIMEOUT_TICKS=4, FADE_STEP=0x30, lint_out=0x80; stop frames and give one tick per PWM period.
  - After the 4th tick, timeout=1.
  - lint_out steps 0x50 → 0x20 → 0x00 on successive commits, then the state is DARK.
  - red_out is unchanged throughout.
- In DARK, send a frame with lint 0x40 → timeout drops the next cycle and lint_out=0x40 at the next pwm_sof.
- Assert reset while pending=1 mid-fade → all outputs and flags read 0 immediately. After release, pwm_sof produces no applied pulse.
